// File: rtl/inv_eop_pkg.sv
// rtl/inv_eop_pkg.sv - shared types and constants for the inverter-chain stimulus sequencer
// Holds the sequencer state encoding, the minimum check delay after a toggle,
// and the synchronizer depth used on the chain outputs.
package inv_eop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Two synchronizer flops plus at least one cycle for the chain itself.
  localparam int SETTLE_MIN  = 3;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - multi-flop synchronizer for an asynchronous single-bit input
// Ports:
//   sys_clk  in  sampling clock
//   rst      in  synchronous active-high reset, clears every stage
//   d        in  asynchronous input
//   q        out synchronized output, STAGES cycles behind d
module sync2
  import inv_eop_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/stim_seq_ctrl.sv
// rtl/stim_seq_ctrl.sv - counted stimulus burst generator with output polarity self-check
// Drives a gated burst of toggles onto inverter chain A and/or B and counts the
// checks where a synchronized chain output does not equal the inverted stimulus.
// Ports:
//   sys_clk, rst          clock and synchronous active-high reset
//   start                 burst request, honoured only when idle
//   chain_sel             bit0 enables chain A, bit1 enables chain B (latched)
//   half_period           cycles between toggles, 0 runs as 1 (latched)
//   n_edges               toggles per burst, bit0 ignored (latched)
//   settle                cycles after a toggle at which outputs are checked (latched)
//   a_in, b_in            asynchronous chain outputs
//   stim_a, stim_b        registered chain drivers
//   busy, done            burst in progress / one-cycle end-of-burst pulse
//   edge_cnt              toggles issued in the current or last burst
//   mismatch_cnt          failed checks, saturating
module stim_seq_ctrl
  import inv_eop_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       chain_sel,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] n_edges,
  input  logic [3:0]       settle,
  input  logic             a_in,
  input  logic             b_in,
  output logic             stim_a,
  output logic             stim_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [DIV_W-1:0] W_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] S_MIN = DIV_W'(SETTLE_MIN);

  state_t state_q, state_d;

  logic             lvl_q, lvl_d;
  logic             stim_a_q, stim_b_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [DIV_W-1:0] w_q, w_d;
  logic             latch_cfg;

  // Burst configuration captured at start
  logic             sel_a_q, sel_b_q;
  logic [DIV_W-1:0] h_q;
  logic [CNT_W-1:0] n_q;
  logic [DIV_W-1:0] s_q;

  logic             sync_a, sync_b;

  sync2 u_sync_a (.sys_clk(sys_clk), .rst(rst), .d(a_in), .q(sync_a));
  sync2 u_sync_b (.sys_clk(sys_clk), .rst(rst), .d(b_in), .q(sync_b));

  // Effective configuration derived from the live inputs at start time.
  logic [DIV_W-1:0] h_eff;
  logic [DIV_W-1:0] settle_ext;
  logic [DIV_W-1:0] settle_clamp;
  logic [DIV_W-1:0] s_eff;
  logic [CNT_W-1:0] n_eff;

  always_comb begin
    h_eff        = (half_period == '0) ? W_ONE : half_period;
    settle_ext   = DIV_W'(settle);
    settle_clamp = (settle_ext < S_MIN) ? S_MIN : settle_ext;
    // The check must land inside the toggle interval, so cap it at H.
    s_eff        = (settle_clamp < h_eff) ? settle_clamp : h_eff;
    // Forcing N even guarantees the stimulus always returns low.
    n_eff        = {n_edges[CNT_W-1:1], 1'b0};
  end

  // Outputs should read as the inverse of the current level; a synced output
  // equal to lvl is a polarity failure on an enabled chain.
  logic chk_fail;
  assign chk_fail = (sel_a_q && (sync_a == lvl_q)) ||
                    (sel_b_q && (sync_b == lvl_q));

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    edge_d    = edge_q;
    mis_d     = mis_q;
    w_d       = w_q;
    busy_d    = busy_q;
    latch_cfg = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ARM;
          latch_cfg = 1'b1;
          edge_d    = '0;
          mis_d     = '0;
          busy_d    = 1'b1;
        end
      end
      ST_ARM: begin
        if (n_q == '0) begin
          state_d = ST_FINISH;
        end else begin
          lvl_d   = ~lvl_q;
          edge_d  = C_ONE;
          w_d     = W_ONE;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_d = w_q + W_ONE;
        if ((w_q == s_q) && chk_fail && (mis_q != '1)) begin
          mis_d = mis_q + C_ONE;
        end
        if (w_q == h_q) begin
          if (edge_q == n_q) begin
            state_d = ST_FINISH;
          end else begin
            lvl_d  = ~lvl_q;
            edge_d = edge_q + C_ONE;
            w_d    = W_ONE;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done is registered, so raise it on the way into FINISH so it is high
    // for exactly the FINISH cycle.
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lvl_q    <= 1'b0;
      stim_a_q <= 1'b0;
      stim_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      edge_q   <= '0;
      mis_q    <= '0;
      w_q      <= '0;
      sel_a_q  <= 1'b0;
      sel_b_q  <= 1'b0;
      h_q      <= '0;
      n_q      <= '0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      stim_a_q <= lvl_d & sel_a_q;
      stim_b_q <= lvl_d & sel_b_q;
      busy_q   <= busy_d;
      done_q   <= done_d;
      edge_q   <= edge_d;
      mis_q    <= mis_d;
      w_q      <= w_d;
      if (latch_cfg) begin
        sel_a_q <= chain_sel[0];
        sel_b_q <= chain_sel[1];
        h_q     <= h_eff;
        n_q     <= n_eff;
        s_q     <= s_eff;
      end
    end
  end

  assign stim_a       = stim_a_q;
  assign stim_b       = stim_b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign edge_cnt     = edge_q;
  assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// tb/tb_stim_seq_ctrl.sv - self-checking bench for stim_seq_ctrl
module tb_stim_seq_ctrl;

  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

  logic              sys_clk     = 1'b0;
  logic              rst         = 1'b1;
  logic              start       = 1'b0;
  logic [1:0]        chain_sel   = 2'b00;
  logic [DIV_W-1:0]  half_period = '0;
  logic [CNT_W-1:0]  n_edges     = '0;
  logic [3:0]        settle      = '0;
  wire               a_in;
  wire               b_in;
  logic              stim_a, stim_b, busy, done;
  logic [CNT_W-1:0]  edge_cnt, mismatch_cnt;

  // chain behaviour: 0 good inverter, 1 stuck at 0, 2 stuck at 1, 3 non-inverting
  int mode_a = 0;
  int mode_b = 0;

  // second instance with narrow counters for the saturation case
  logic              start_s = 1'b0;
  wire               a_in_s;
  logic              b_in_s  = 1'b0;
  logic              stim_a_s, stim_b_s, busy_s, done_s;
  logic [3:0]        edge_s, mis_s;

  int n_checks = 0;
  int n_pass   = 0;
  int burst_id = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic logic chain_out(input int mode, input logic s);
    case (mode)
      0:       return ~s;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return s;
    endcase
  endfunction

  assign #1 a_in   = chain_out(mode_a, stim_a);
  assign #1 b_in   = chain_out(mode_b, stim_b);
  assign #1 a_in_s = stim_a_s;

  stim_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .chain_sel(chain_sel),
    .half_period(half_period), .n_edges(n_edges), .settle(settle),
    .a_in(a_in), .b_in(b_in), .stim_a(stim_a), .stim_b(stim_b),
    .busy(busy), .done(done), .edge_cnt(edge_cnt), .mismatch_cnt(mismatch_cnt)
  );

  stim_seq_ctrl #(.DIV_W(8), .CNT_W(4)) dut_sat (
    .sys_clk(sys_clk), .rst(rst), .start(start_s), .chain_sel(2'b01),
    .half_period(8'd4), .n_edges(4'd14), .settle(4'd3),
    .a_in(a_in_s), .b_in(b_in_s), .stim_a(stim_a_s), .stim_b(stim_b_s),
    .busy(busy_s), .done(done_s), .edge_cnt(edge_s), .mismatch_cnt(mis_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s (burst %0d) observed=%0h expected=%0h", tag, burst_id, obs, exp);
  endtask

  // A check lands after the synchronizers have settled, so a chain fails a
  // check purely from its behaviour and the level it was driven to.
  function automatic bit chain_fails(input int mode, input int lvl);
    case (mode)
      0:       return 1'b0;
      1:       return (lvl == 0);
      2:       return (lvl == 1);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int exp_mismatch(input logic [1:0] sel, input int ne,
                                      input int ma, input int mb);
    int cnt = 0;
    for (int j = 1; j <= ne; j++) begin
      if ((sel[0] && chain_fails(ma, j % 2)) || (sel[1] && chain_fails(mb, j % 2)))
        cnt++;
    end
    return cnt;
  endfunction

  // Runs one burst and checks every cycle against the toggle schedule.
  // pulse_c > 0 re-asserts start before that cycle; abort_c > 0 resets there.
  task automatic run_burst(input logic [1:0] sel, input int h, input int n, input int st,
                           input int ma, input int mb, input int pulse_c, input int abort_c);
    int he, ne, last, tog, lvl, em;
    burst_id = burst_id + 1;
    he   = (h == 0) ? 1 : h;
    ne   = n - (n % 2);
    last = (ne == 0) ? 1 : 1 + ne * he;
    em   = exp_mismatch(sel, ne, ma, mb);
    @(negedge sys_clk);
    mode_a      = ma;
    mode_b      = mb;
    chain_sel   = sel;
    half_period = DIV_W'(h);
    n_edges     = CNT_W'(n);
    settle      = 4'(st);
    start       = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    // scramble the live config: the burst must keep the latched values
    chain_sel   = 2'($urandom);
    half_period = DIV_W'($urandom);
    n_edges     = CNT_W'($urandom);
    settle      = 4'($urandom);
    chk("busy_at_start", busy, 1);
    chk("edge_cleared", edge_cnt, 0);
    chk("mis_cleared", mismatch_cnt, 0);
    for (int c = 1; c <= last + 1; c++) begin
      if (c == pulse_c) start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      tog = (ne == 0) ? 0 : (((c - 1) / he + 1) < ne ? ((c - 1) / he + 1) : ne);
      lvl = tog % 2;
      chk("stim_a", stim_a, (sel[0] && lvl == 1) ? 1 : 0);
      chk("stim_b", stim_b, (sel[1] && lvl == 1) ? 1 : 0);
      chk("edge_cnt", edge_cnt, tog);
      chk("done", done, (c == last) ? 1 : 0);
      chk("busy", busy, (c <= last) ? 1 : 0);
      if (c >= last) chk("mismatch_cnt", mismatch_cnt, em);
      if (c == abort_c) begin
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        chk("abort_stim_a", stim_a, 0);
        chk("abort_stim_b", stim_b, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_edge", edge_cnt, 0);
        chk("abort_mis", mismatch_cnt, 0);
        @(posedge sys_clk);
        #1;
        chk("abort_no_done", done, 0);
        return;
      end
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_stim_a", stim_a, 0);
    chk("rst_stim_b", stim_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_edge", edge_cnt, 0);
    chk("rst_mis", mismatch_cnt, 0);
    chk("rst_sat_busy", busy_s, 0);
    chk("rst_sat_mis", mis_s, 0);
    rst = 1'b0;

    // loopback, 6 toggles spaced 4 cycles, done 25 cycles after start edge
    run_burst(2'b11, 4, 6, 3, 0, 0, 0, 0);
    // chain B stuck at 0: fails on the checks where lvl is 0
    run_burst(2'b11, 5, 4, 3, 0, 1, 0, 0);
    run_burst(2'b01, 5, 4, 3, 0, 1, 0, 0);
    // H=0 runs as H=1, odd N rounds down
    run_burst(2'b00, 0, 3, 3, 0, 0, 0, 0);
    // N=0 finishes without toggling
    run_burst(2'b11, 4, 0, 3, 0, 0, 0, 0);
    // settle beyond H clamps to H
    run_burst(2'b11, 4, 4, 15, 0, 2, 0, 0);
    // start during a burst is ignored
    run_burst(2'b11, 4, 6, 3, 0, 0, 6, 0);
    // reset when edge_cnt reaches 3, then a clean burst
    run_burst(2'b11, 4, 6, 3, 0, 0, 0, 9);
    run_burst(2'b10, 3, 4, 3, 0, 3, 0, 0);
    // all-disabled burst makes no checks even with broken chains
    run_burst(2'b00, 3, 4, 3, 3, 3, 0, 0);

    for (int i = 0; i < 8; i++) begin
      run_burst(2'($urandom_range(0, 3)), $urandom_range(3, 8), $urandom_range(0, 12),
                $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    // saturation: preload the narrow counter near max, then 14 failing checks
    burst_id = burst_id + 1;
    @(negedge sys_clk);
    start_s = 1'b1;
    @(posedge sys_clk);
    #1;
    start_s = 1'b0;
    force dut_sat.mis_q = 4'd13;
    @(posedge sys_clk);
    #1;
    release dut_sat.mis_q;
    waited = 0;
    while (!done_s && waited < 200) begin
      @(posedge sys_clk);
      #1;
      waited++;
    end
    chk("sat_done_seen", done_s, 1);
    chk("sat_edge", edge_s, 14);
    chk("sat_mis", mis_s, 15);
    @(posedge sys_clk);
    #1;
    chk("sat_mis_hold", mis_s, 15);
    chk("sat_busy_low", busy_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
